stream_mux_rr: RTL and testbench



---
 rtl/stream_mux_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/stream_mux_rr.sv | 116 +++++++++++
 tb/tb_stream_mux_rr.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_mux_pkg.sv
// Shared definitions for the round-robin stream multiplexer.
//   MODE_RR / MODE_FIXED : encodings of the mode input
//   next_ptr(cur, n)     : increment with wrap at n-1 (n need not be a power of two)
package stream_mux_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

    // Advance a channel index by one, returning to zero after the last channel.
    function automatic int unsigned next_ptr(input int unsigned cur, input int unsigned n);
        int unsigned nxt_s;
        if (cur + 32'd1 >= n) begin
            nxt_s = 32'd0;
        end else begin
            nxt_s = cur + 32'd1;
        end
        return nxt_s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req       : per-channel requests
//   ptr       : highest-priority channel this cycle (must be < N)
//   en        : when low, nothing is granted
//   grant     : one-hot grant, or all zero
//   grant_idx : index of the granted channel (0 when nothing is granted)
// The fixed-select path reuses this block by presenting a request vector
// with at most one bit set, so the rotation has no effect there.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    input  logic                 en,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int SELW = $clog2(N);

    logic found_s;

    // Scan ptr, ptr+1, ... wrapping at N-1, and grant the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end else begin
                idx = idx;
            end
            if (en && !found_s && req[idx]) begin
                grant[idx] = 1'b1;
                grant_idx  = SELW'(idx);
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output slot.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : N input streams, channel i at in_data[i*WIDTH +: WIDTH]
//   in_ready            : per-channel ready, combinational from in_valid/out_ready
//   mode, select        : 0 = round-robin, 1 = fixed channel 'select'
//   out_data/out_chan   : registered word and the channel it came from
//   out_valid/out_ready : output handshake
// The slot refills in the same cycle it drains, giving one word per cycle.
module stream_mux_rr
    import stream_mux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic               mode,
    input  logic [SELW-1:0]    select,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_chan,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [WIDTH-1:0] out_data_r;
    logic [SELW-1:0]  out_chan_r;
    logic             out_valid_r;
    logic [SELW-1:0]  ptr_r;

    logic             load_en_s;
    logic [N-1:0]     sel_mask_s;
    logic [N-1:0]     req_s;
    logic [N-1:0]     grant_s;
    logic [SELW-1:0]  grant_idx_s;
    logic             xfer_s;
    logic [WIDTH-1:0] mux_data_s;

    assign load_en_s = !out_valid_r || out_ready;

    // Decode select into a one-hot mask; an out-of-range select matches nothing.
    always_comb begin
        sel_mask_s = '0;
        for (int i = 0; i < N; i++) begin
            if (select == SELW'(i)) begin
                sel_mask_s[i] = 1'b1;
            end else begin
                sel_mask_s[i] = 1'b0;
            end
        end
    end

    // Fixed mode narrows the request vector to the selected channel.
    always_comb begin
        if (mode == MODE_FIXED) begin
            req_s = in_valid & sel_mask_s;
        end else begin
            req_s = in_valid;
        end
    end

    rr_arbiter #(
        .N(N)
    ) u_arb (
        .req       (req_s),
        .ptr       (ptr_r),
        .en        (load_en_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // rst_n gates ready so no handshake is offered while the block is held in reset.
    assign in_ready = grant_s & {N{load_en_s & rst_n}};
    assign xfer_s   = |(in_ready & in_valid);

    // AND-OR data selection over the one-hot grant.
    always_comb begin
        mux_data_s = '0;
        for (int i = 0; i < N; i++) begin
            mux_data_s = mux_data_s | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
        end
    end

    // Output slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_r  <= '0;
            out_chan_r  <= '0;
            out_valid_r <= 1'b0;
            ptr_r       <= '0;
        end else begin
            if (xfer_s) begin
                out_data_r  <= mux_data_s;
                out_chan_r  <= grant_idx_s;
                out_valid_r <= 1'b1;
                if (mode == MODE_RR) begin
                    ptr_r <= SELW'(next_ptr(32'(grant_idx_s), N));
                end else begin
                    ptr_r <= ptr_r;
                end
            end else if (out_ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

    assign out_data  = out_data_r;
    assign out_chan  = out_chan_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int N3 = 3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_valid = '0;
    logic [N-1:0]   in_ready;
    logic           mode = 1'b0;
    logic [1:0]     select = 2'd0;
    logic [W-1:0]   out_data;
    logic [1:0]     out_chan;
    logic           out_valid;
    logic           out_ready = 1'b1;

    logic [N3*W-1:0] d3_in_data = '0;
    logic [N3-1:0]   d3_in_valid = '0;
    logic [N3-1:0]   d3_in_ready;
    logic            d3_mode = 1'b0;
    logic [1:0]      d3_select = 2'd0;
    logic [W-1:0]    d3_out_data;
    logic [1:0]      d3_out_chan;
    logic            d3_out_valid;
    logic            d3_out_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit         m_valid;
    logic [W-1:0] m_data;
    int         m_chan;
    int         m_ptr;

    always #5 clk = ~clk;

    stream_mux_rr #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mode(mode), .select(select), .out_data(out_data),
        .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
    );

    stream_mux_rr #(.WIDTH(W), .N(N3)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .mode(d3_mode), .select(d3_select), .out_data(d3_out_data),
        .out_chan(d3_out_chan), .out_valid(d3_out_valid), .out_ready(d3_out_ready)
    );

    function automatic int model_grant(logic [N-1:0] v, logic md, int sel, int p);
        if (md) begin
            if (sel < N && v[sel]) return sel;
            return -1;
        end
        for (int k = 0; k < N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int g;
        logic [N-1:0] r;
        r = '0;
        g = model_grant(in_valid, mode, int'(select), m_ptr);
        if (g >= 0 && (!m_valid || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_chan  = 0;
        m_ptr   = 0;
    endtask

    // Advance one clock, updating the model with the inputs present at the edge.
    task automatic cycle();
        int g;
        bit ld;
        g  = model_grant(in_valid, mode, int'(select), m_ptr);
        ld = !m_valid || out_ready;
        @(posedge clk);
        if (ld && g >= 0) begin
            m_data  = in_data[g*W +: W];
            m_chan  = g;
            m_valid = 1'b1;
            if (mode == 1'b0) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_data_inc(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) in_data[i*W +: W] = base + W'(i);
    endtask

    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        in_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || out_chan !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: valid=%b data=%h chan=%0d required 0/00/0", out_valid, out_data, out_chan);
        end
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b required 0000", in_ready);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rr_fair();
        mode = 1'b0;
        out_ready = 1'b1;
        in_valid = 4'b1111;
        set_data_inc(8'h10);
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++;
            if (in_ready !== model_ready()) begin
                errors++;
                $display("FAIL rr_ready[%0d]: got %b required %b", c, in_ready, model_ready());
            end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'(c % 4) || out_data !== 8'h10 + 8'(c % 4)) begin
                errors++;
                $display("FAIL rr_fair[%0d]: valid=%b chan=%0d data=%h required 1/%0d/%h",
                         c, out_valid, out_chan, out_data, c % 4, 8'h10 + 8'(c % 4));
            end
        end
    endtask

    task automatic test_sparse();
        int exp_seq[3] = '{1, 3, 1};
        in_valid = 4'b1010;
        for (int c = 0; c < 3; c++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || int'(out_chan) != exp_seq[c] || int'(out_chan) != m_chan) begin
                errors++;
                $display("FAIL sparse[%0d]: chan=%0d required %0d", c, out_chan, exp_seq[c]);
            end
        end
    endtask

    task automatic test_backpressure();
        set_data_inc(8'h10);
        in_data[2*W +: W] = 8'hA5;
        mode = 1'b1;
        select = 2'd2;
        in_valid = 4'b0100;
        out_ready = 1'b1;
        cycle();
        mode = 1'b0;
        in_valid = 4'b1111;
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (in_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_ready[%0d]: got %b required 0000", c, in_ready);
            end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_chan !== 2'd2) begin
                errors++;
                $display("FAIL bp_hold[%0d]: valid=%b data=%h chan=%0d required 1/a5/2", c, out_valid, out_data, out_chan);
            end
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== model_ready() || in_ready === 4'b0000) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required %b", in_ready, model_ready());
        end
        for (int c = 0; c < 2; c++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b1 || int'(out_chan) != m_chan || out_data !== m_data) begin
                errors++;
                $display("FAIL bp_b2b[%0d]: valid=%b chan=%0d data=%h required 1/%0d/%h",
                         c, out_valid, out_chan, out_data, m_chan, m_data);
            end
        end
    endtask

    task automatic test_fixed();
        mode = 1'b1;
        select = 2'd2;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_data = $urandom;
            #1;
            checks++;
            if (in_ready !== 4'b0100) begin
                errors++;
                $display("FAIL fixed_ready[%0d]: got %b required 0100", c, in_ready);
            end
            cycle();
            checks++;
            if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== m_data) begin
                errors++;
                $display("FAIL fixed_out[%0d]: chan=%0d data=%h required 2/%h", c, out_chan, out_data, m_data);
            end
        end
        select = 2'd3;
        in_valid = 4'b0111;
        #1;
        checks++;
        if (in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL fixed_sel3_ready: got %b required 0000", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fixed_drain: out_valid=%b required 0", out_valid);
        end
        in_valid = 4'b0000;
        mode = 1'b0;
    endtask

    task automatic test_n3();
        int exp_seq[4] = '{0, 1, 2, 0};
        for (int i = 0; i < N3; i++) d3_in_data[i*W +: W] = 8'h20 + W'(i);
        d3_mode = 1'b0;
        d3_in_valid = 3'b111;
        d3_out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            cycle();
            checks++;
            if (d3_out_valid !== 1'b1 || int'(d3_out_chan) != exp_seq[c] || d3_out_data !== 8'h20 + 8'(exp_seq[c])) begin
                errors++;
                $display("FAIL n3_wrap[%0d]: chan=%0d data=%h required %0d", c, d3_out_chan, d3_out_data, exp_seq[c]);
            end
        end
        d3_mode = 1'b1;
        d3_select = 2'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (d3_in_ready !== 3'b000) begin
                errors++;
                $display("FAIL n3_sel3_ready[%0d]: got %b required 000", c, d3_in_ready);
            end
            cycle();
            checks++;
            if (d3_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL n3_sel3_valid[%0d]: got %b required 0", c, d3_out_valid);
            end
        end
        d3_in_valid = 3'b000;
    endtask

    task automatic test_midreset();
        mode = 1'b0;
        set_data_inc(8'h40);
        in_valid = 4'b1111;
        out_ready = 1'b0;
        cycle();
        cycle();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (out_valid !== 1'b0 || out_chan !== 2'd0 || in_ready !== 4'b0000) begin
            errors++;
            $display("FAIL midreset_async: valid=%b chan=%0d ready=%b required 0/0/0000", out_valid, out_chan, in_ready);
        end
        in_valid = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 4'b1111;
        out_ready = 1'b1;
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h40) begin
            errors++;
            $display("FAIL midreset_restart: valid=%b chan=%0d data=%h required 1/0/40", out_valid, out_chan, out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            in_data   = $urandom;
            in_valid  = 4'($urandom_range(0, 15));
            mode      = ($urandom_range(0, 3) == 0);
            select    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++;
            if (in_ready !== model_ready() || !$onehot0(in_ready)) begin
                errors++;
                $display("FAIL rand_ready[%0d]: got %b required %b", c, in_ready, model_ready());
            end
            cycle();
            checks++;
            if (out_valid !== m_valid || (m_valid && (out_data !== m_data || int'(out_chan) != m_chan))) begin
                errors++;
                $display("FAIL rand_out[%0d]: valid=%b data=%h chan=%0d required %b/%h/%0d",
                         c, out_valid, out_data, out_chan, m_valid, m_data, m_chan);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_fair();
        test_sparse();
        test_backpressure();
        test_fixed();
        test_n3();
        test_midreset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
